// File: rtl/err_inject_pkg.sv
// err_inject_pkg: scheduler state encoding and default widths shared by the err_inject_sched slice.
package err_inject_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, INJECT} state_e;
  localparam int INW_DEF = 1;
  localparam int LCL_DEF = 1;
  localparam int DW_DEF  = 8;
  localparam int LW_DEF  = 8;
endpackage

// File: rtl/err_inject_sched_if.sv
// err_inject_sched_if: command handshake and splitter-facing outputs of the injection scheduler.
// ERR_INJECT_SCHED_PERIODIC_EN adds the cmd_periodic command bit.
interface err_inject_sched_if
  import err_inject_pkg::*;
#(
  parameter int INW = INW_DEF,
  parameter int DW  = DW_DEF,
  parameter int LW  = LW_DEF
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [INW-1:0] cmd_target;
  logic [DW-1:0]  cmd_delay;
  logic [LW-1:0]  cmd_len;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
  logic           cmd_periodic;
`endif
  logic           abort;
  logic           err_en;
  logic [INW-1:0] err_ctrl;
  logic           busy;
  logic           done;
  logic           bad_tgt;
  modport master (
    output cmd_valid, cmd_target, cmd_delay, cmd_len, abort,
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
    output cmd_periodic,
`endif
    input  cmd_ready, err_en, err_ctrl, busy, done, bad_tgt
  );
  modport slave (
    input  cmd_valid, cmd_target, cmd_delay, cmd_len, abort,
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
    input  cmd_periodic,
`endif
    output cmd_ready, err_en, err_ctrl, busy, done, bad_tgt
  );
endinterface

// File: rtl/err_sched_cnt.sv
// err_sched_cnt: loadable down-counter that saturates at 1, shared by the delay and length phases.
module err_sched_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         is_one_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && cnt_q > W'(1)) cnt_q <= cnt_q - W'(1);
  assign is_one_o = cnt_q == W'(1);
endmodule

// File: rtl/err_inject_sched.sv
// err_inject_sched: schedules a delayed err_en burst on a chosen error site for the local splitter.
// ERR_INJECT_SCHED_PERIODIC_EN enables repeating bursts until abort.
module err_inject_sched
  import err_inject_pkg::*;
#(
  parameter int INW = INW_DEF,
  parameter int LCL = LCL_DEF,
  parameter int DW  = DW_DEF,
  parameter int LW  = LW_DEF
) (
  input logic clk,
  input logic rst_n,
  err_inject_sched_if.slave bus
);
  localparam int CW = DW > LW ? DW : LW;
  state_e         state_q, state_d;
  logic [INW-1:0] ctrl_q, ctrl_d;
  logic [LW-1:0]  len_q, len_d, len_in;
  logic           en_q, done_q, done_d, bad_q, bad_d;
  logic           acc, legal, one, ld;
  logic [CW-1:0]  ld_val;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
  logic           per_q, per_d;
  logic [DW-1:0]  dly_q, dly_d;
`endif
  assign bus.cmd_ready = state_q == IDLE && !bus.abort;
  assign acc           = bus.cmd_valid && bus.cmd_ready;
  assign legal         = 32'(bus.cmd_target) < 32'(LCL);
  assign len_in        = bus.cmd_len == '0 ? LW'(1) : bus.cmd_len;
  assign bus.err_en    = en_q;
  assign bus.err_ctrl  = ctrl_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.bad_tgt   = bad_q;
  err_sched_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ld),
    .dec_i    (state_q != IDLE),
    .val_i    (ld_val),
    .is_one_o (one)
  );
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    len_d   = len_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
    per_d   = per_q;
    dly_d   = dly_q;
`endif
    if (state_q == IDLE) begin
      if (acc && !legal) bad_d = 1'b1;
      else if (acc) begin
        ctrl_d  = bus.cmd_target;
        len_d   = len_in;
        ld      = 1'b1;
        state_d = bus.cmd_delay == '0 ? INJECT : WAIT;
        ld_val  = bus.cmd_delay == '0 ? CW'(len_in) : CW'(bus.cmd_delay);
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
        per_d   = bus.cmd_periodic;
        dly_d   = bus.cmd_delay;
`endif
      end
    end else if (bus.abort) state_d = IDLE;
    else if (one && state_q == WAIT) begin
      ld      = 1'b1;
      ld_val  = CW'(len_q);
      state_d = INJECT;
    end else if (one) begin
      done_d  = 1'b1;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
      ld      = per_q;
      ld_val  = dly_q == '0 ? CW'(len_q) : CW'(dly_q);
      state_d = !per_q ? IDLE : (dly_q == '0 ? INJECT : WAIT);
`else
      state_d = IDLE;
`endif
    end
  end
  // err_en is a flop tracking the state so the splitter sees a glitch-free enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
      per_q   <= 1'b0;
      dly_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      len_q   <= len_d;
      en_q    <= state_d == INJECT;
      done_q  <= done_d;
      bad_q   <= bad_d;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
      per_q   <= per_d;
      dly_q   <= dly_d;
`endif
    end
endmodule

// File: tb/tb_err_inject_sched.sv
// tb_err_inject_sched: scoreboard bench; the model schedules expected err_en/done/bad_tgt cycles per accepted command.
module tb_err_inject_sched;
  localparam int LCL = 4;
  typedef struct { int cyc; int tgt; } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk = 1'b0;
  bit   exp_ready, exp_busy;
  int   ctrl_exp = 0, ctrl_pend = 0, free_at = 0, acc_c = -1;
  ev_t  en_s[$], done_s[$], bad_s[$];
  err_inject_sched_if #(.INW(3), .DW(4), .LW(4)) bus ();
  err_inject_sched #(.INW(3), .LCL(LCL), .DW(4), .LW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", n, cyc, act, exp);
    end
  endfunction
  always @(negedge clk) if (chk) begin
    bit e;
    check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("err_ctrl", 32'(bus.err_ctrl), ctrl_exp);
    e = en_s.size() > 0 && en_s[0].cyc == cyc;
    check("err_en", 32'(bus.err_en), 32'(e));
    if (e) en_s.delete(0);
    e = done_s.size() > 0 && done_s[0].cyc == cyc;
    check("done", 32'(bus.done), 32'(e));
    if (e) done_s.delete(0);
    e = bad_s.size() > 0 && bad_s[0].cyc == cyc;
    check("bad_tgt", 32'(bus.bad_tgt), 32'(e));
    if (e) bad_s.delete(0);
  end
  task automatic drive(input bit v, input int t, input int d, input int l, input bit a);
    ev_t e;
    int  len;
    @(posedge clk);
    #2;
    ctrl_exp = ctrl_pend;
    bus.cmd_valid  = v;
    bus.cmd_target = 3'(t);
    bus.cmd_delay  = 4'(d);
    bus.cmd_len    = 4'(l);
    bus.abort      = a;
    exp_ready = cyc >= free_at && !a;
    exp_busy  = cyc > acc_c && cyc < free_at;
    if (a && exp_busy) begin
      while (en_s.size() > 0 && en_s[$].cyc > cyc) en_s.delete(en_s.size() - 1);
      while (done_s.size() > 0 && done_s[$].cyc > cyc) done_s.delete(done_s.size() - 1);
      free_at = cyc + 1;
    end
    if (v && exp_ready) begin
      acc_c = cyc;
      e.tgt = t;
      if (t >= LCL) begin
        e.cyc = cyc + 1;
        bad_s.push_back(e);
        free_at = cyc + 1;
      end else begin
        len = l == 0 ? 1 : l;
        ctrl_pend = t;
        for (int k = 1; k <= len; k++) begin
          e.cyc = cyc + d + k;
          en_s.push_back(e);
        end
        e.cyc = cyc + 1 + d + len;
        done_s.push_back(e);
        free_at = e.cyc;
      end
    end
    chk = 1'b1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_delay = '0;
    bus.cmd_len = '0;
    bus.abort = 1'b0;
`ifdef ERR_INJECT_SCHED_PERIODIC_EN
    bus.cmd_periodic = 1'b0;
`endif
    #1;
    check("rst_err_en", 32'(bus.err_en), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err_ctrl", 32'(bus.err_ctrl), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 1, 3, 2, 0);
    idle(8);
    drive(1, 2, 0, 0, 0);
    idle(4);
    drive(1, 5, 2, 2, 0);
    idle(4);
    drive(1, 2, 0, 5, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    idle(3);
    drive(1, 1, 0, 0, 1);
    idle(3);
    drive(1, 3, 1, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    idle(4);
    drive(1, 3, 5, 3, 0);
    idle(2);
    chk = 1'b0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check("arst_err_en", 32'(bus.err_en), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_err_ctrl", 32'(bus.err_ctrl), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_bad_tgt", 32'(bus.bad_tgt), 0);
    en_s.delete();
    done_s.delete();
    bad_s.delete();
    free_at = 0;
    acc_c = -1;
    ctrl_pend = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(10);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 4)), $urandom_range(0, 39) == 0);
    idle(30);
    check("en_drained", en_s.size(), 0);
    check("done_drained", done_s.size(), 0);
    check("bad_drained", bad_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
